mem_access_unit: RTL

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// M-stage load/store unit: aligns and lane-places stores, extracts and extends loads,
// raises address/bus exceptions and stalls the pipeline for one outstanding bus access.
module mem_access_unit #(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 32,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req_valid,
   input  logic                req_we,
   input  logic [1:0]          req_size,
   input  logic                req_signed,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [DATA_W-1:0]   req_wdata,
   input  logic                flush,
   output logic                mem_req,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W/8-1:0] mem_wstrb,
   output logic [DATA_W-1:0]   mem_wdata,
   input  logic                mem_ack,
   input  logic [DATA_W-1:0]   mem_rdata,
   output logic                stall,
   output logic                done,
   output logic [DATA_W-1:0]   rdata,
   output logic                exc_adel,
   output logic                exc_ades,
   output logic                exc_bus,
   output logic [ADDR_W-1:0]   bad_addr
);

   localparam int   NB    = DATA_W / 8;
   localparam int   OFS   = $clog2(NB);
   localparam int   CNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
   localparam logic TO_EN = (TIMEOUT_CYC != 0);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t              state, state_next;
   logic                we_q, signed_q, cancel_q, bus_err_q;
   logic [1:0]          size_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q, rdata_q;
   logic [CNT_W-1:0]    cnt_q;

   logic                aligned, accept, illegal_req, busy, ack_hit, timeout;
   logic [DATA_W-1:0]   shifted, load_ext, wdata_lane;
   logic [NB-1:0]       wstrb_lane;
   logic [7:0]          mask8;
   logic                sbit;
   int                  nbits;

   always_comb begin
      aligned = 1'b1;
      case (req_size)
         2'd1:    aligned = ~req_addr[0];
         2'd2:    aligned = (req_addr[1:0] == 2'b00);
         2'd3:    aligned = (req_addr[2:0] == 3'b000) && (DATA_W == 64);
         default: aligned = 1'b1;
      endcase
   end

   assign busy        = (state == S_BUSY);
   assign accept      = (state == S_IDLE) & req_valid & ~flush & aligned;
   assign illegal_req = (state == S_IDLE) & req_valid & ~flush & ~aligned;
   assign ack_hit     = busy & mem_ack;
   // Ack in the same cycle as the limit is reached takes priority over the timeout.
   assign timeout     = busy & ~mem_ack & TO_EN & (cnt_q == CNT_W'(TIMEOUT_CYC));

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:  if (accept) state_next = S_BUSY;
         S_BUSY:  if (ack_hit || timeout) state_next = S_DONE;
         S_DONE:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         we_q      <= 1'b0;
         signed_q  <= 1'b0;
         size_q    <= 2'd0;
         addr_q    <= '0;
         wdata_q   <= '0;
         cnt_q     <= '0;
         cancel_q  <= 1'b0;
         bus_err_q <= 1'b0;
         rdata_q   <= '0;
      end else begin
         if (accept) begin
            we_q      <= req_we;
            signed_q  <= req_signed;
            size_q    <= req_size;
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            cnt_q     <= '0;
            cancel_q  <= 1'b0;
            bus_err_q <= 1'b0;
         end
         if (busy) begin
            if (flush)    cancel_q <= 1'b1;
            if (!mem_ack) cnt_q    <= cnt_q + 1'b1;
            if (ack_hit) begin
               rdata_q   <= load_ext;
               bus_err_q <= 1'b0;
            end else if (timeout) begin
               rdata_q   <= '0;
               bus_err_q <= 1'b1;
            end
         end
      end
   end

   // Load path: bring the addressed lane down to bit 0, then extend above the access size.
   always_comb begin
      shifted = mem_rdata >> {addr_q[OFS-1:0], 3'b000};
      case (size_q)
         2'd0:    begin nbits = 8;      sbit = shifted[7];        end
         2'd1:    begin nbits = 16;     sbit = shifted[15];       end
         2'd2:    begin nbits = 32;     sbit = shifted[31];       end
         default: begin nbits = DATA_W; sbit = shifted[DATA_W-1]; end
      endcase
      load_ext = '0;
      for (int i = 0; i < DATA_W; i++)
         load_ext[i] = (i < nbits) ? shifted[i] : (signed_q & sbit);
   end

   always_comb begin
      wdata_lane = '0;
      for (int i = 0; i < DATA_W; i++) begin
         case (size_q)
            2'd0:    wdata_lane[i] = wdata_q[i % 8];
            2'd1:    wdata_lane[i] = wdata_q[i % 16];
            2'd2:    wdata_lane[i] = wdata_q[i % 32];
            default: wdata_lane[i] = wdata_q[i];
         endcase
      end
      case (size_q)
         2'd0:    mask8 = 8'h01;
         2'd1:    mask8 = 8'h03;
         2'd2:    mask8 = 8'h0F;
         default: mask8 = 8'hFF;
      endcase
      wstrb_lane = we_q ? (NB'(mask8) << addr_q[OFS-1:0]) : '0;
   end

   always_comb begin
      mem_req   = busy;
      mem_we    = busy & we_q;
      mem_addr  = busy ? {addr_q[ADDR_W-1:OFS], {OFS{1'b0}}} : '0;
      mem_wstrb = busy ? wstrb_lane : '0;
      mem_wdata = busy ? wdata_lane : '0;
      stall     = accept | busy;
      done      = ((state == S_DONE) & ~cancel_q) | illegal_req;
      exc_adel  = illegal_req & ~req_we;
      exc_ades  = illegal_req & req_we;
      exc_bus   = (state == S_DONE) & ~cancel_q & bus_err_q;
      rdata     = rdata_q;
      if (illegal_req)  bad_addr = req_addr;
      else if (exc_bus) bad_addr = addr_q;
      else              bad_addr = '0;
   end

endmodule
